// File: rtl/cs_out_fifo.sv
// Show-ahead output FIFO behind the 9-sample smoother: drops warm-up samples, buffers valid results.
// Optional drop counter port drop_cnt is enabled by defining CS_OUT_DROPCNT_EN.
module cs_out_fifo #(
  parameter int DEPTH  = 16,
  parameter int WARMUP = 9,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    Y,
  input  logic          in_valid,
  output logic [9:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow
`ifdef CS_OUT_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [WW-1:0] wcnt_reg;
  logic [AW-1:0] wp_reg;
  logic [AW-1:0] rp_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          overflow_reg;
  logic [9:0]    mem [DEPTH];

  logic warm;
  logic push_req;
  logic pop;
  logic push_acc;

  assign warm      = (wcnt_reg == WW'(WARMUP));
  assign push_req  = in_valid && warm;
  assign out_valid = (level_reg != '0);
  assign full      = (level_reg == (AW+1)'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_acc  = push_req && (!full || pop);

  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign out_data = out_valid ? mem[rp_reg] : '0;

  always_comb begin
    level_next = level_reg;
    case ({push_acc, pop})
      2'b10:   level_next = level_reg + (AW+1)'(1);
      2'b01:   level_next = level_reg - (AW+1)'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_reg     <= '0;
      wp_reg       <= '0;
      rp_reg       <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (in_valid && !warm)
        wcnt_reg <= wcnt_reg + WW'(1);
      if (push_acc)
        wp_reg <= wp_reg + AW'(1);
      if (pop)
        rp_reg <= rp_reg + AW'(1);
      level_reg <= level_next;
      if (push_req && !push_acc)
        overflow_reg <= 1'b1;
    end
  end

  // Storage is never cleared; level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_acc)
      mem[wp_reg] <= Y;
  end

`ifdef CS_OUT_DROPCNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt_reg <= '0;
    else if (push_req && !push_acc && drop_cnt_reg != 8'hFF)
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_cs_out_fifo.sv
// Scoreboard bench for cs_out_fifo: stimulus queues expected outputs, a negedge monitor checks pops.
module tb_cs_out_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] Y;
  logic       in_valid;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       full;
  logic       overflow;
`ifdef CS_OUT_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  cs_out_fifo #(.DEPTH(16), .WARMUP(9)) dut (
    .clk       (clk),
    .reset     (reset),
    .Y         (Y),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`ifdef CS_OUT_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One rising edge with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input int y, input bit iv, input bit rdy);
    Y = 10'(y);
    in_valid = iv;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake visible at negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %0d, expected no output", out_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(out_data) != e) begin
          n_fail++;
          $display("FAIL pop_data: got %0d, expected %0d", out_data, e);
        end else begin
          $display("pop data=%0d", out_data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cycle(0, 1'b0, 1'b0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_out_data", int'(out_data), 0);
`ifdef CS_OUT_DROPCNT_EN
    check("rst_drop_cnt", int'(drop_cnt), 0);
`endif
    reset = 1'b0;

    // Warm-up: Y=1..9 discarded, 10..20 emerge
    for (int i = 1; i <= 20; i++) begin
      if (i >= 10) exp_q.push_back(i);
      cycle(i, 1'b1, 1'b1);
      if (i == 9)  check("warm_valid_after9", int'(out_valid), 0);
      if (i == 10) check("warm_valid_after10", int'(out_valid), 1);
      if (i == 10) check("warm_first_data", int'(out_data), 10);
    end
    cycle(0, 1'b0, 1'b1);
    check("warm_drained_level", int'(level), 0);

    // Backpressure fill
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(100 + i);
      cycle(100 + i, 1'b1, 1'b0);
      check("fill_head_stable", int'(out_data), 100);
    end
    check("fill_full", int'(full), 1);
    check("fill_level", int'(level), 16);
    check("fill_overflow", int'(overflow), 0);

    // Overflow: 999 dropped
    cycle(999, 1'b1, 1'b0);
    check("ovf_overflow", int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    check("ovf_head", int'(out_data), 100);
`ifdef CS_OUT_DROPCNT_EN
    check("ovf_drop_cnt", int'(drop_cnt), 1);
`endif

    // Full with simultaneous push and pop
    exp_q.push_back(200);
    cycle(200, 1'b1, 1'b1);
    check("fullpp_level", int'(level), 16);
    check("fullpp_full", int'(full), 1);
    check("fullpp_overflow", int'(overflow), 1);
    check("fullpp_head", int'(out_data), 101);
    for (int i = 0; i < 16; i++) cycle(0, 1'b0, 1'b1);
    check("fullpp_drained", int'(level), 0);

    // Wrap-around with out_ready toggling
    for (int i = 0; i < 40; i++) begin
      bit iv;
      iv = (i % 4) != 0;
      if (iv) exp_q.push_back(300 + i);
      cycle(300 + i, iv, (i % 2) == 0);
      check("wrap_level_bound", int'(level <= 5'd16), 1);
    end
    check("wrap_overflow_kept", int'(overflow), 1);
    for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b1);
    check("wrap_drained", int'(level), 0);

    // Mid-stream reset with 5 entries queued (these are flushed, not expected)
    for (int i = 0; i < 5; i++) cycle(400 + i, 1'b1, 1'b0);
    check("mrst_pre_level", int'(level), 5);
    reset = 1'b1;
    cycle(0, 1'b0, 1'b0);
    reset = 1'b0;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_level", int'(level), 0);
    check("mrst_overflow", int'(overflow), 0);
`ifdef CS_OUT_DROPCNT_EN
    check("mrst_drop_cnt", int'(drop_cnt), 0);
`endif
    for (int i = 0; i < 10; i++) begin
      if (i == 9) exp_q.push_back(509);
      cycle(500 + i, 1'b1, 1'b1);
      if (i == 8) check("mrst_valid_after9", int'(out_valid), 0);
    end
    check("mrst_valid_after10", int'(out_valid), 1);
    cycle(0, 1'b0, 1'b1);
    check("mrst_drained", int'(level), 0);

    cycle(0, 1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
